debounce_pulser: RTL and testbench

- Conditions one raw asynchronous input, such as a push-button or switch, for the lab flip-flop and counter stages.
- Pipeline: two-or-more-flop synchronizer, then a debounce state machine, then an edge detector.
- Outputs: a clean debounced level, a single-cycle rise pulse, a single-cycle fall pulse, and a wrapping press counter.
- Directly feeds the `d`/enable input of the downstream flip-flop and counter stages, so they see exactly one clean event per physical press.

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/debounce_pulser_if.sv | 14 +
 rtl/sync_chain.sv | 38 +++
 rtl/debounce_pulser.sv | 119 +++++++++++
 tb/tb_debounce_pulser.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button / switch conditioning path.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;  // 10 ms at 100 MHz
    localparam int COUNT_WIDTH_DEF     = 8;

    // Debounce counter width; never below 1 bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/debounce_pulser_if.sv
// Bundles the raw input and conditioned outputs of one debounce_pulser so a
// driver (master) and the conditioning block (slave) can be wired as a unit.
interface debounce_pulser_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   din;
    logic                   level;
    logic                   rise;
    logic                   fall;
    logic [COUNT_WIDTH-1:0] press_count;

    modport master (output din, input level, rise, fall, press_count);
    modport slave  (input din, output level, rise, fall, press_count);
endinterface

// File: rtl/sync_chain.sv
// Reset-to-0 D flop and a parameterized chain of them used to bring an
// asynchronous input into the clk domain.
module dff_r0 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    always_ff @(posedge clk) begin
        if (reset) q <= 1'b0;
        else       q <= d;
    end
endmodule

module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] stage_q;
    logic [STAGES-1:0] stage_d;

    assign stage_d = {stage_q[STAGES-2:0], d};

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        dff_r0 u_ff (
            .clk   (clk),
            .reset (reset),
            .d     (stage_d[i]),
            .q     (stage_q[i])
        );
    end

    assign q = stage_q[STAGES-1];
endmodule

// File: rtl/debounce_pulser.sv
// Synchronizer -> debounce FSM -> registered rise/fall pulses and a wrapping
// press counter, giving downstream stages one clean event per physical press.
module debounce_pulser
    import debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int COUNT_WIDTH     = COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   din,
    output logic                   level,
    output logic                   rise,
    output logic                   fall,
    output logic [COUNT_WIDTH-1:0] press_count
);
    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                   sync;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (din),
        .q     (sync)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            count_q <= count_d;
        end
    end

    // A WAIT state needs DEBOUNCE_CYCLES consecutive agreeing samples: the one
    // that left the STABLE state (cnt=1) plus DEBOUNCE_CYCLES-1 more.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        count_d = count_q;
        case (state_q)
            STABLE_LOW: begin
                if (sync) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    count_d = count_q + 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!sync) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign level       = level_q;
    assign rise        = rise_q;
    assign fall        = fall_q;
    assign press_count = count_q;
endmodule

// File: tb/tb_debounce_pulser.sv
// Directed stimulus pushes expected rise/fall events into a queue; a negedge
// monitor pops and compares every pulse the DUT emits.
module tb_debounce_pulser;
    localparam int CW = 8;

    typedef struct packed {
        logic          is_rise;
        int            edge_no;
        logic [CW-1:0] cnt;
        logic          lvl;
    } exp_t;

    logic clk;
    logic reset;
    int   edge_n;
    int   checks;
    int   failures;
    int   rises_seen;
    int   model_cnt;
    int   base;
    exp_t exp_q[$];

    debounce_pulser_if #(.COUNT_WIDTH(CW)) bus ();

    debounce_pulser #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .COUNT_WIDTH     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .din         (bus.din),
        .level       (bus.level),
        .rise        (bus.rise),
        .fall        (bus.fall),
        .press_count (bus.press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        if (bus.rise || bus.fall) begin
            exp_t e;
            checks++;
            if (bus.rise) rises_seen++;
            if (bus.rise && bus.fall) begin
                failures++;
                $display("FAIL pulse_overlap edge=%0d rise=1 fall=1 required one at most", edge_n);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse edge=%0d rise=%0b fall=%0b required none", edge_n, bus.rise, bus.fall);
            end else begin
                e = exp_q.pop_front();
                if (e.is_rise !== bus.rise || e.edge_no != edge_n ||
                    e.cnt !== bus.press_count || e.lvl !== bus.level) begin
                    failures++;
                    $display("FAIL pulse_event got rise=%0b edge=%0d count=%0d level=%0b required rise=%0b edge=%0d count=%0d level=%0b",
                             bus.rise, edge_n, bus.press_count, bus.level,
                             e.is_rise, e.edge_no, e.cnt, e.lvl);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic expect_pulse(input logic is_rise, input int ed);
        exp_t e;
        if (is_rise) model_cnt = (model_cnt + 1) % 256;
        e.is_rise = is_rise;
        e.edge_no = ed;
        e.cnt     = CW'(model_cnt);
        e.lvl     = is_rise;
        exp_q.push_back(e);
    endtask

    // Drive a clean new din level; the edge lands 6 edges later (2 sync + 4 debounce).
    task automatic drive_clean(input logic v, input int hold);
        bus.din = v;
        base = edge_n;
        expect_pulse(v, base + 6);
        step(hold);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        model_cnt = 0;
    endtask

    initial begin
        checks = 0; failures = 0; rises_seen = 0; model_cnt = 0;
        reset = 1'b1;
        bus.din = 1'b1;

        // 1: reset held 3 edges with din high, then debounced from scratch
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("reset_level", 32'(bus.level), 0);
            chk("reset_rise",  32'(bus.rise), 0);
            chk("reset_fall",  32'(bus.fall), 0);
            chk("reset_count", 32'(bus.press_count), 0);
        end
        reset = 1'b0;
        drive_clean(1'b1, 10);
        chk("after_reset_count", 32'(bus.press_count), 1);

        // 2: clean press from a fresh reset
        bus.din = 1'b0;
        do_reset();
        chk("reset_from_high_level", 32'(bus.level), 0);
        step(4);
        bus.din = 1'b1;
        base = edge_n;
        expect_pulse(1'b1, base + 6);
        step(5);
        chk("press_e5_rise",  32'(bus.rise), 0);
        chk("press_e5_level", 32'(bus.level), 0);
        step(1);
        chk("press_e6_rise",  32'(bus.rise), 1);
        chk("press_e6_level", 32'(bus.level), 1);
        chk("press_e6_count", 32'(bus.press_count), 1);
        step(1);
        chk("press_e7_rise",  32'(bus.rise), 0);
        step(7);

        // 3: bounce, needs a low level first
        drive_clean(1'b0, 10);
        for (int i = 0; i < 10; i++) begin
            bus.din = 1'b1; step(3);
            bus.din = 1'b0; step(1);
        end
        step(8);
        chk("bounce_level", 32'(bus.level), 0);
        chk("bounce_count", 32'(bus.press_count), 1);

        // 4: release with explicit edge-6 check, then 1-cycle low glitch
        drive_clean(1'b1, 10);
        bus.din = 1'b0;
        base = edge_n;
        expect_pulse(1'b0, base + 6);
        step(5);
        chk("release_e5_level", 32'(bus.level), 1);
        step(1);
        chk("release_e6_fall",  32'(bus.fall), 1);
        chk("release_e6_level", 32'(bus.level), 0);
        chk("release_e6_count", 32'(bus.press_count), 2);
        step(4);
        drive_clean(1'b1, 10);
        bus.din = 1'b0; step(1);
        bus.din = 1'b1; step(10);
        chk("glitch_level", 32'(bus.level), 1);
        drive_clean(1'b0, 10);

        // Toggling every cycle keeps the outputs frozen
        for (int i = 0; i < 20; i++) begin
            bus.din = ~bus.din;
            step(1);
        end
        bus.din = 1'b0;
        step(8);
        chk("toggle_level", 32'(bus.level), 0);

        // 5: wrap over 256 presses
        do_reset();
        begin
            int r0;
            r0 = rises_seen;
            for (int i = 1; i <= 256; i++) begin
                drive_clean(1'b1, 6);
                if (i == 255) chk("wrap_count_255", 32'(bus.press_count), 255);
                if (i == 256) chk("wrap_count_256", 32'(bus.press_count), 0);
                drive_clean(1'b0, 6);
            end
            step(2);
            chk("wrap_rises", 32'(rises_seen - r0), 256);
        end

        // 6: reset mid-wait aborts the press
        do_reset();
        step(4);
        bus.din = 1'b1;
        step(3);
        reset = 1'b1;
        step(1);
        chk("midwait_reset_level", 32'(bus.level), 0);
        reset = 1'b0;
        model_cnt = 0;
        base = edge_n;
        expect_pulse(1'b1, base + 6);
        step(10);
        chk("midwait_count", 32'(bus.press_count), 1);

        // 6b: reset while level=1 drops level without a fall
        reset = 1'b1;
        step(1);
        chk("high_reset_level", 32'(bus.level), 0);
        chk("high_reset_fall",  32'(bus.fall), 0);
        reset = 1'b0;
        model_cnt = 0;
        base = edge_n;
        expect_pulse(1'b1, base + 6);
        step(10);
        chk("high_reset_relevel", 32'(bus.level), 1);

        step(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses got_pending=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
